// File: rtl/hazard_pkg.sv
// Shared state encodings and parameter defaults for the hazard controller.
package hazard_pkg;
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_STALL    = 2'd1;
    localparam logic [1:0] ST_WAIT_MEM = 2'd2;

    localparam int LU_STALL_CYC_DEF = 1;
    localparam int WAIT_MAX_DEF     = 255;
    localparam int CNT_W_DEF        = 16;

    // Holds the remaining bubble count; wide enough for LU_STALL_CYC up to 7.
    localparam int REM_W = 3;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats a same-cycle increment.
// One-edge latency from inc to count; no backpressure, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, memory-busy freeze.
// Controls are combinational from state and inputs; counters/timeout settle one edge later.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LU_STALL_CYC = LU_STALL_CYC_DEF,
    parameter int WAIT_MAX     = WAIT_MAX_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             mem_pcsrc,
    input  logic             mem_busy,
    input  logic             clr_cnt,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout,
    output logic [1:0]       state
);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    logic [1:0]       r_state;
    logic [1:0]       r_saved_state;
    logic [REM_W-1:0] r_rem;
    logic [WAIT_W-1:0] r_wait;
    logic             r_timeout;

    logic             w_hz;
    logic [1:0]       w_eff_state;
    logic [1:0]       w_nxt_state;
    logic [REM_W-1:0] w_nxt_rem;
    logic             w_pcw;
    logic             w_bubble;
    logic             w_flush;
    logic             w_freeze;

    assign w_hz = id_valid & ex_memread & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    // Once memory releases, behave exactly as the state we were frozen in.
    assign w_eff_state = (r_state == ST_WAIT_MEM) ? r_saved_state : r_state;

    always_comb begin
        w_pcw       = 1'b1;
        w_bubble    = 1'b0;
        w_flush     = 1'b0;
        w_freeze    = 1'b0;
        w_nxt_state = ST_RUN;
        w_nxt_rem   = r_rem;
        if (mem_busy) begin
            w_pcw       = 1'b0;
            w_freeze    = 1'b1;
            w_nxt_state = ST_WAIT_MEM;
        end else if (mem_pcsrc) begin
            w_flush   = 1'b1;
            w_nxt_rem = '0;
        end else if (w_eff_state == ST_STALL) begin
            w_pcw       = 1'b0;
            w_bubble    = 1'b1;
            w_nxt_rem   = r_rem - 1'b1;
            w_nxt_state = (r_rem == REM_W'(1)) ? ST_RUN : ST_STALL;
        end else if (w_hz) begin
            w_pcw       = 1'b0;
            w_bubble    = 1'b1;
            w_nxt_rem   = REM_W'(LU_STALL_CYC - 1);
            w_nxt_state = (LU_STALL_CYC > 1) ? ST_STALL : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_saved_state <= ST_RUN;
            r_rem         <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_rem   <= w_nxt_rem;
            if (mem_busy && (r_state != ST_WAIT_MEM)) begin
                r_saved_state <= r_state;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!mem_busy) begin
                r_wait <= '0;
            end else if (r_wait != WAIT_W'(WAIT_MAX)) begin
                r_wait <= r_wait + 1'b1;
            end
            if (clr_cnt) begin
                r_timeout <= 1'b0;
            end else if (mem_busy && ((int'(r_wait) + 1) >= WAIT_MAX)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Controls are forced quiet while reset is held.
    assign pc_write     = rst_n & w_pcw;
    assign if_id_write  = rst_n & w_pcw;
    assign id_ex_bubble = rst_n & w_bubble;
    assign if_id_flush  = rst_n & w_flush;
    assign id_ex_flush  = rst_n & w_flush;
    assign ex_mem_flush = rst_n & w_flush;
    assign freeze       = rst_n & w_freeze;
    assign mem_timeout  = r_timeout;
    assign state        = r_state;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (id_ex_bubble),
        .clr   (clr_cnt),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_id_flush),
        .clr   (clr_cnt),
        .cnt   (flush_cnt)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations (LU=1/WAIT=255/16b and LU=3/WAIT=3/4b) share inputs,
// each tracked by an owed-bubble model; plus a vector table and directed corner sequences.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_uses_rt, ex_memread, mem_pcsrc, mem_busy, clr_cnt;
    logic [4:0] id_rs, id_rt, ex_rt;

    logic a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf, a_frz, a_to;
    logic b_pcw, b_ifw, b_bub, b_iff, b_idf, b_exf, b_frz, b_to;
    logic [1:0]  a_st, b_st;
    logic [15:0] a_sc, a_fc;
    logic [3:0]  b_sc, b_fc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LU_STALL_CYC(1), .WAIT_MAX(255), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_pcsrc(mem_pcsrc),
        .mem_busy(mem_busy), .clr_cnt(clr_cnt), .pc_write(a_pcw), .if_id_write(a_ifw),
        .id_ex_bubble(a_bub), .if_id_flush(a_iff), .id_ex_flush(a_idf), .ex_mem_flush(a_exf),
        .freeze(a_frz), .stall_cnt(a_sc), .flush_cnt(a_fc), .mem_timeout(a_to), .state(a_st)
    );

    hazard_ctrl #(.LU_STALL_CYC(3), .WAIT_MAX(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_pcsrc(mem_pcsrc),
        .mem_busy(mem_busy), .clr_cnt(clr_cnt), .pc_write(b_pcw), .if_id_write(b_ifw),
        .id_ex_bubble(b_bub), .if_id_flush(b_iff), .id_ex_flush(b_idf), .ex_mem_flush(b_exf),
        .freeze(b_frz), .stall_cnt(b_sc), .flush_cnt(b_fc), .mem_timeout(b_to), .state(b_st)
    );

    // Reference model: bubbles still owed, consecutive busy run, and plain integer counters.
    int P_LU[2]  = '{1, 3};
    int P_WM[2]  = '{255, 3};
    int P_MAX[2] = '{65535, 15};
    int m_owed[2], m_brun[2], m_sc[2], m_fc[2];
    bit m_to[2], m_last_busy[2];

    typedef struct {
        logic       vld;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       mr;
        logic [4:0] ert;
        logic       busy;
        logic       pcsrc;
        logic       e_pcw;
        logic       e_bub;
        logic       e_fl;
        logic       e_frz;
    } vec_t;
    vec_t tbl[12];

    logic [2:0] exp042[4] = '{3'b100, 3'b101, 3'b101, 3'b000};
    logic [2:0] exp044[3] = '{3'b110, 3'b101, 3'b000};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit hz_ref();
        return id_valid && ex_memread && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

    function automatic logic [41:0] obs_a();
        return {a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf, a_frz, a_to, a_st, a_sc, a_fc};
    endfunction

    function automatic logic [41:0] obs_b();
        return {b_pcw, b_ifw, b_bub, b_iff, b_idf, b_exf, b_frz, b_to, b_st,
                12'd0, b_sc, 12'd0, b_fc};
    endfunction

    task automatic model_check(input int i, input logic [41:0] act);
        bit h, bub, fl, frz, pcw;
        logic [1:0]  st;
        logic [15:0] sc, fc;
        if (!rst_n) begin
            m_owed[i] = 0; m_brun[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            m_to[i] = 0; m_last_busy[i] = 0;
        end
        h   = hz_ref();
        frz = mem_busy;
        fl  = !mem_busy && mem_pcsrc;
        bub = !mem_busy && !mem_pcsrc && ((m_owed[i] > 0) || h);
        pcw = !frz && !bub;
        st  = m_last_busy[i] ? 2'd2 : ((m_owed[i] > 0) ? 2'd1 : 2'd0);
        if (!rst_n) begin
            pcw = 0; bub = 0; fl = 0; frz = 0;
        end
        sc = 16'(m_sc[i]);
        fc = 16'(m_fc[i]);
        chk(i == 0 ? "model_a" : "model_b", act,
            {22'd0, pcw, pcw, bub, fl, fl, fl, frz, m_to[i], st, sc, fc});
        if (rst_n) begin
            if (mem_busy) begin
                m_brun[i]++;
                if (m_brun[i] >= P_WM[i]) m_to[i] = 1;
            end else begin
                m_brun[i] = 0;
                if (mem_pcsrc) m_owed[i] = 0;
                else if (m_owed[i] > 0) m_owed[i]--;
                else if (h) m_owed[i] = P_LU[i] - 1;
            end
            if (clr_cnt) begin
                m_sc[i] = 0; m_fc[i] = 0; m_to[i] = 0;
            end else begin
                if (bub && m_sc[i] < P_MAX[i]) m_sc[i]++;
                if (fl && m_fc[i] < P_MAX[i]) m_fc[i]++;
            end
            m_last_busy[i] = mem_busy;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check(0, obs_a());
        model_check(1, obs_b());
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_memread = 0; ex_rt = 0;
        mem_pcsrc = 0; mem_busy = 0; clr_cnt = 0;
    endtask

    task automatic set_hz();
        id_valid = 1; id_rs = 5'd2; id_rt = 5'd7; id_uses_rt = 0; ex_memread = 1; ex_rt = 5'd2;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        adv();
        rst_n = 1;
    endtask

    initial begin
        idle();
        // Power-on reset state
        tick();
        chk("rst_ctrl_a", {a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf, a_frz, a_to}, 0);
        chk("rst_ctrl_b", {b_pcw, b_ifw, b_bub, b_iff, b_idf, b_exf, b_frz, b_to}, 0);
        chk("rst_regs", {a_st, b_st, a_sc, a_fc, b_sc, b_fc}, 0);
        adv();
        rst_n = 1;

        // Hazard detect and priority table against the LU=1 instance
        tbl[0]  = '{1, 2, 5, 0, 1, 2, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{1, 5, 2, 1, 1, 2, 0, 0, 0, 1, 0, 0};
        tbl[2]  = '{1, 5, 2, 0, 1, 2, 0, 0, 1, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
        tbl[4]  = '{0, 2, 2, 1, 1, 2, 0, 0, 1, 0, 0, 0};
        tbl[5]  = '{1, 2, 2, 1, 0, 2, 0, 0, 1, 0, 0, 0};
        tbl[6]  = '{1, 2, 5, 0, 1, 2, 0, 1, 1, 0, 1, 0};
        tbl[7]  = '{1, 2, 5, 0, 1, 2, 1, 0, 0, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[10] = '{1, 31, 4, 0, 1, 31, 0, 0, 0, 1, 0, 0};
        tbl[11] = '{1, 0, 31, 1, 1, 31, 0, 0, 0, 1, 0, 0};
        for (int k = 0; k < 12; k++) begin
            id_valid = tbl[k].vld; id_rs = tbl[k].rs; id_rt = tbl[k].rt;
            id_uses_rt = tbl[k].uses; ex_memread = tbl[k].mr; ex_rt = tbl[k].ert;
            mem_busy = tbl[k].busy; mem_pcsrc = tbl[k].pcsrc;
            tick();
            chk($sformatf("tbl%0d", k), {a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf, a_frz},
                {tbl[k].e_pcw, tbl[k].e_pcw, tbl[k].e_bub, tbl[k].e_fl, tbl[k].e_fl,
                 tbl[k].e_fl, tbl[k].e_frz});
            adv();
        end
        idle();

        // Single load-use bubble with LU=1
        do_reset();
        set_hz();
        tick();
        chk("lu1_bubble", {a_pcw, a_ifw, a_bub}, 3'b001);
        adv();
        idle();
        tick();
        chk("lu1_after", {a_st, a_sc}, {2'd0, 16'd1});
        adv();

        // LU=3: three bubbles, states 0,1,1,0
        do_reset();
        set_hz();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) idle();
            tick();
            chk($sformatf("lu3_step%0d", k), {b_bub, b_st}, exp042[k]);
            adv();
        end
        chk("lu3_cnt", b_sc, 4'd3);

        // Branch flush in the middle of a stall
        do_reset();
        set_hz();
        tick();
        adv();
        idle();
        mem_pcsrc = 1;
        tick();
        chk("br_flush", {b_iff, b_idf, b_exf, b_bub, b_pcw, b_ifw, b_st}, {6'b111011, 2'd1});
        adv();
        mem_pcsrc = 0;
        tick();
        chk("br_after", {b_st, b_bub, b_fc}, {2'd0, 1'b0, 4'd1});
        adv();

        // Memory busy for four cycles with two bubbles still owed
        do_reset();
        set_hz();
        tick();
        adv();
        idle();
        mem_busy = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("busy%0d", k), {b_frz, b_pcw, b_ifw, b_bub, b_iff, b_to},
                {5'b10000, (k == 3)});
            adv();
        end
        mem_busy = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("resume%0d", k), {b_bub, b_st}, exp044[k]);
            adv();
        end
        chk("resume_cnt", {b_sc, b_to}, {4'd3, 1'b1});
        clr_cnt = 1;
        tick();
        adv();
        clr_cnt = 0;
        tick();
        chk("clr_all", {b_to, b_sc, b_fc}, 0);
        adv();

        // Clear wins over a same-cycle increment
        set_hz();
        clr_cnt = 1;
        tick();
        adv();
        idle();
        tick();
        chk("clr_vs_inc", a_sc, 16'd0);
        adv();

        // Register zero never stalls
        do_reset();
        id_valid = 1; ex_memread = 1; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 1;
        tick();
        chk("rt_zero", {a_bub, b_bub, a_pcw, b_pcw}, 4'b0011);
        adv();

        // Counter saturation
        set_hz();
        repeat (20) begin
            tick();
            adv();
        end
        tick();
        chk("sat_b", {b_sc, a_sc}, {4'hF, 16'd20});
        adv();
        idle();
        tick();
        chk("sat_hold", b_sc, 4'hF);
        adv();

        // Reset in the middle of a stall
        do_reset();
        set_hz();
        tick();
        adv();
        idle();
        tick();
        chk("mid_stall", b_st, 2'd1);
        adv();
        rst_n = 0;
        #1;
        chk("rst_async_ctl", {b_pcw, b_ifw, b_bub, b_frz, b_iff, b_idf, b_exf, b_to}, 0);
        chk("rst_async_reg", {b_st, b_sc}, 0);
        tick();
        adv();
        rst_n = 1;
        tick();
        chk("rst_release", {b_st, b_bub, b_pcw}, {2'd0, 1'b0, 1'b1});
        adv();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            id_valid   = ($urandom_range(0, 4) != 0);
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            ex_rt      = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
            ex_memread = 1'($urandom_range(0, 1));
            mem_pcsrc  = ($urandom_range(0, 7) == 0);
            mem_busy   = mem_busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
            clr_cnt    = ($urandom_range(0, 39) == 0);
            tick();
            adv();
        end
        rst_n = 1;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
